// File: rtl/spi_bus_arbiter_pkg.sv
// Shared encodings and helpers for the two-requester SPI bus arbiter.
package spi_bus_arbiter_pkg;

   // Arbiter phases; the encoding is exported on dbg_state.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSetup = 3'd1,
      StOwned = 3'd2,
      StDrain = 3'd3,
      StHold  = 3'd4,
      StGap   = 3'd5
   } arb_state_e;

   // Owner indices: requester 0 drives the MFRC522, requester 1 the EEPROM.
   localparam logic SpiDevNfc    = 1'b0;
   localparam logic SpiDevEeprom = 1'b1;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_cyc_timer.sv
// cyc_timer: loadable saturating down-counter; zero flag marks the end of a phase.
module spi_bus_arbiter_cyc_timer #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [Width-1:0] i_value,
   output logic             o_zero
);

   logic [Width-1:0] r_cnt;

   // Load wins; otherwise count down and stick at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - Width'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_master between two requesters, owning both chip selects and
// their setup/hold/gap timing, with round-robin arbitration and a watchdog.
module spi_bus_arbiter
   import spi_bus_arbiter_pkg::*;
#(
   parameter int unsigned CS_SETUP_CYCLES = 4,
   parameter int unsigned CS_HOLD_CYCLES  = 4,
   parameter int unsigned CS_GAP_CYCLES   = 8,
   parameter int unsigned MAX_OWN_CYCLES  = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       r0_req,
   input  logic       r1_req,
   output logic       r0_gnt,
   output logic       r1_gnt,
   input  logic       r0_start,
   input  logic       r1_start,
   input  logic [7:0] r0_tx_byte,
   input  logic [7:0] r1_tx_byte,
   output logic       r0_done,
   output logic       r1_done,
   output logic [7:0] rx_byte,
   output logic       spi_start_xfer,
   output logic [7:0] spi_tx_byte,
   input  logic       spi_xfer_active,
   input  logic       spi_xfer_done,
   input  logic [7:0] spi_rx_byte,
   output logic       spi_cs_0,
   output logic       spi_cs_1,
   output logic       owner,
   output logic       timeout_fault,
   output logic [7:0] dbg_state
);

   localparam int unsigned TmrMax = max3(CS_SETUP_CYCLES, CS_HOLD_CYCLES, CS_GAP_CYCLES);
   localparam int unsigned TmrW   = $clog2(TmrMax + 1);
   localparam logic [TmrW-1:0] SetupLd = TmrW'(CS_SETUP_CYCLES - 1);
   localparam logic [TmrW-1:0] HoldLd  = TmrW'(CS_HOLD_CYCLES - 1);
   localparam logic [TmrW-1:0] GapLd   = TmrW'(CS_GAP_CYCLES - 1);

   localparam int unsigned WdW = (MAX_OWN_CYCLES == 0) ? 1 : $clog2(MAX_OWN_CYCLES + 1);
   localparam logic [WdW-1:0] WdLast = WdW'((MAX_OWN_CYCLES == 0) ? 0 : MAX_OWN_CYCLES - 1);
   localparam logic [WdW-1:0] WdSat  = WdW'(MAX_OWN_CYCLES);

   arb_state_e     r_state;
   arb_state_e     w_state_nxt;
   logic           r_owner;
   logic           r_rr;
   logic           r_fault;
   logic [1:0]     r_lock;
   logic [WdW-1:0] r_wd;

   logic            w_tmr_load;
   logic [TmrW-1:0] w_tmr_val;
   logic            w_tmr_zero;
   logic [1:0]      w_req_ok;
   logic            w_winner;
   logic            w_own_req;
   logic            w_own_start;
   logic [7:0]      w_own_tx;
   logic            w_start_xfer;
   logic            w_wd_expire;
   logic            w_own_enter;
   logic            w_cs_act;
   logic            w_route;

   spi_bus_arbiter_cyc_timer #(
      .Width (TmrW)
   ) u_cyc_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_zero  (w_tmr_zero)
   );

   // A requester locked out by the watchdog stays out until its req is seen low.
   assign w_req_ok     = {r1_req & ~r_lock[1], r0_req & ~r_lock[0]};
   assign w_winner     = (&w_req_ok) ? r_rr : w_req_ok[1];
   assign w_own_req    = (r_owner == SpiDevEeprom) ? r1_req : r0_req;
   assign w_own_start  = (r_owner == SpiDevEeprom) ? r1_start : r0_start;
   assign w_own_tx     = (r_owner == SpiDevEeprom) ? r1_tx_byte : r0_tx_byte;
   assign w_start_xfer = (r_state == StOwned) & w_own_start & ~spi_xfer_active;
   // A done in the expiring cycle clears the count, so it rescues the owner.
   assign w_wd_expire  = (MAX_OWN_CYCLES != 0) & (r_state == StOwned) & ~spi_xfer_done &
                         (r_wd == WdLast);
   assign w_own_enter  = (r_state != StOwned) & (w_state_nxt == StOwned);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; every entry into a timed phase reloads the shared timer.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_val   = '0;
      unique case (r_state)
         StIdle: begin
            if (|w_req_ok) begin
               w_state_nxt = StSetup;
               w_tmr_load  = 1'b1;
               w_tmr_val   = SetupLd;
            end
         end
         StSetup: begin
            if (!w_own_req) begin
               w_state_nxt = StGap;
               w_tmr_load  = 1'b1;
               w_tmr_val   = GapLd;
            end else if (w_tmr_zero) begin
               w_state_nxt = StOwned;
            end
         end
         StOwned: begin
            if (!w_own_req || w_wd_expire) begin
               // A byte in flight (or launched now) must finish before CS may move.
               if ((spi_xfer_active && !spi_xfer_done) || w_start_xfer) begin
                  w_state_nxt = StDrain;
               end else begin
                  w_state_nxt = StHold;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = HoldLd;
               end
            end
         end
         StDrain: begin
            if (spi_xfer_done) begin
               w_state_nxt = StHold;
               w_tmr_load  = 1'b1;
               w_tmr_val   = HoldLd;
            end
         end
         StHold: begin
            if (w_tmr_zero) begin
               w_state_nxt = StGap;
               w_tmr_load  = 1'b1;
               w_tmr_val   = GapLd;
            end
         end
         StGap: begin
            if (w_tmr_zero) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Owner, round-robin pointer, sticky fault and per-requester lockout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= SpiDevNfc;
         r_rr    <= SpiDevNfc;
         r_fault <= 1'b0;
         r_lock  <= 2'b00;
      end else begin
         if (r_state == StIdle && |w_req_ok) begin
            r_owner <= w_winner;
         end
         if (r_state == StGap) begin
            r_rr <= ~r_owner;
         end
         if (w_wd_expire) begin
            r_fault <= 1'b1;
         end
         if (!r0_req) begin
            r_lock[0] <= 1'b0;
         end else if (w_wd_expire && r_owner == SpiDevNfc) begin
            r_lock[0] <= 1'b1;
         end
         if (!r1_req) begin
            r_lock[1] <= 1'b0;
         end else if (w_wd_expire && r_owner == SpiDevEeprom) begin
            r_lock[1] <= 1'b1;
         end
      end
   end

   // Watchdog: counts cycles since OWNED entry or the last completed byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd <= '0;
      end else if (w_own_enter || spi_xfer_done) begin
         r_wd <= '0;
      end else if ((r_state == StOwned || r_state == StDrain) && r_wd != WdSat) begin
         r_wd <= r_wd + WdW'(1);
      end
   end

   // Outputs decoded from the registered state and owner.
   always_comb begin
      w_cs_act       = (r_state == StSetup) | (r_state == StOwned) |
                       (r_state == StDrain) | (r_state == StHold);
      w_route        = (r_state == StOwned) | (r_state == StDrain);
      spi_cs_0       = ~(w_cs_act & (r_owner == SpiDevNfc));
      spi_cs_1       = ~(w_cs_act & (r_owner == SpiDevEeprom));
      r0_gnt         = (r_state == StOwned) & (r_owner == SpiDevNfc);
      r1_gnt         = (r_state == StOwned) & (r_owner == SpiDevEeprom);
      r0_done        = spi_xfer_done & w_route & (r_owner == SpiDevNfc);
      r1_done        = spi_xfer_done & w_route & (r_owner == SpiDevEeprom);
      spi_start_xfer = w_start_xfer;
      spi_tx_byte    = (r_state == StOwned) ? w_own_tx : 8'h00;
      rx_byte        = spi_rx_byte;
      owner          = r_owner;
      timeout_fault  = r_fault;
      dbg_state      = 8'(r_state);
   end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single `spi_master` (Mode 0, one byte per transfer) between two requesters on the board SPI bus.
  - Requester 0: `nfc_card_detector`, driving the MFRC522 on `spi_cs_0`.
  - Requester 1: the EEPROM controller, driving the EEPROM on `spi_cs_1`.
- Owns both chip selects and enforces CS setup, hold and deselect-gap timing.
- Grants the bus for whole multi-byte transactions, using round-robin between simultaneous requesters.
- A per-transaction watchdog reclaims the bus from a stalled owner.

Parameters:
- CS_SETUP_CYCLES, 4: clk cycles of CS low before grant (min 1).
- CS_HOLD_CYCLES, 4: clk cycles CS stays low after the last byte completes (min 1).
- CS_GAP_CYCLES, 8: clk cycles both CS high before the next selection (min 1).
- MAX_OWN_CYCLES, 65535: max cycles in OWNED without an `xfer_done`; 0 disables the watchdog.

Ports:
- clk  in  1  system clock (32 MHz)
- rst_n  in  1  asynchronous active-low reset
- r0_req, r1_req  in  1  requester holds high for the whole transaction
- r0_gnt, r1_gnt  out  1  bus granted to requester
- r0_start, r1_start  in  1  one-cycle byte start strobe
- r0_tx_byte, r1_tx_byte  in  8  byte to send
- r0_done, r1_done  out  1  byte complete, owner only
- rx_byte  out  8  received byte, broadcast
- spi_start_xfer  out  1  to `spi_master`
- spi_tx_byte  out  8  to `spi_master`
- spi_xfer_active  in  1  from `spi_master`
- spi_xfer_done  in  1  from `spi_master`
- spi_rx_byte  in  8  from `spi_master`
- spi_cs_0, spi_cs_1  out  1  active-low chip selects
- owner  out  1  current/last owner index
- timeout_fault  out  1  sticky watchdog flag

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE; `spi_cs_0` = `spi_cs_1` = 1; `r0_gnt` = `r1_gnt` = 0.
  - `spi_start_xfer` = 0; `spi_tx_byte` = 0; `owner` = 0; round-robin pointer prefers r0; `timeout_fault` = 0; counters = 0.
- States: IDLE, SETUP, OWNED, DRAIN, HOLD, GAP.
- IDLE:
  - If exactly one req is high, that requester wins.
  - If both are high, the pointer's preferred requester wins.
  - Next cycle: `owner` = winner, its CS = 0, state = SETUP.
- SETUP:
  - After CS_SETUP_CYCLES cycles go to OWNED; gnt rises on OWNED entry.
  - req-to-gnt latency is therefore CS_SETUP_CYCLES+1 cycles.
  - If the owner's req drops during SETUP, go directly to GAP (CS high, no HOLD).
- OWNED:
  - `spi_start_xfer` = owner start & gnt & ~`spi_xfer_active` (combinational); `spi_tx_byte` = owner `tx_byte`.
  - Starts from the non-owner are ignored. Starts while `spi_xfer_active` is high are dropped.
  - Owner `done` = `spi_xfer_done`; non-owner `done` = 0.
  - `rx_byte` = `spi_rx_byte` continuously.
  - On owner req low:
    - if `spi_xfer_active` or a start was issued this cycle, go to DRAIN;
    - else go to HOLD.
  - gnt drops on leaving OWNED.
- DRAIN: wait for `spi_xfer_done`, which is still routed to the owner; then go to HOLD.
- HOLD: CS low for CS_HOLD_CYCLES, then CS high and go to GAP.
- GAP:
  - Both CS high for CS_GAP_CYCLES.
  - Round-robin pointer = other requester.
  - Then go to IDLE; a waiting req is arbitrated in that IDLE cycle.
- Watchdog:
  - Counter clears on entry to OWNED and on every `spi_xfer_done`; it increments in OWNED and DRAIN.
  - At MAX_OWN_CYCLES: set `timeout_fault`, drop gnt, go to DRAIN if active, else HOLD.
  - The owner must drop req before it can be re-granted; a held req is not re-arbitrated until it is seen low once.
  - `timeout_fault` clears only on reset.
- Invariants:
  - Never both CS low.
  - CS only changes with `spi_xfer_active` = 0.
  - gnt is one-hot or zero.
- Counters are $clog2(max param + 1) wide and saturate (no wrap).
- Back-to-back transactions by the same requester, with the other idle, still pass HOLD, GAP and SETUP.

Decomposition:
- Shared header `spi_bus_defs.vh`:
  - state encodings (localparams), for the 8-bit `dbg_state` export;
  - owner index defines: `SPI_DEV_NFC` = 0, `SPI_DEV_EEPROM` = 1.
- One sub-module `cyc_timer`: loadable saturating down-counter with a `zero` flag, shared by the SETUP, HOLD and GAP phases.
- The watchdog uses its own up-counter.

Test Plan:
- r0_req only, defaults:
  - `spi_cs_0` falls 1 cycle after req; `r0_gnt` rises 5 cycles after req.
  - 3 starts with bytes 0x26, 0x00, 0x7F each produce `r0_done`; `spi_cs_1` stays 1.
- r0 and r1 req the same cycle after reset:
  - r0 granted first; r1 granted after r0's HOLD(4) + GAP(8) + SETUP(4).
  - Next contention is won by r1.
- r1 drops req while a byte is in flight:
  - state goes to DRAIN; CS stays low until `spi_xfer_done`, then 4 more cycles; `r1_gnt` low immediately.
- r1_start pulsed while r0 owns:
  - no `spi_start_xfer`; `r1_done` never asserts; `spi_cs_1` stays 1.
- MAX_OWN_CYCLES=16, r0 holds req with no starts:
  - `timeout_fault` = 1 at cycle 16 of OWNED; `r0_gnt` = 0; `spi_cs_0` high 4 cycles later.
  - r0 not re-granted until its req toggles.
- rst_n asserted mid-byte:
  - all outputs immediately at reset values (both CS = 1, gnt = 0); normal arbitration resumes after release.
